// File: rtl/register_bank.sv
// Parametrised operand register bank: two read ports, write, swap, shadow
// save/restore and a one-register-per-cycle sequential clear.
module register_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                swap_en,
  input  logic [ADDR_W-1:0]   swap_a,
  input  logic [ADDR_W-1:0]   swap_b,
  input  logic                save,
  input  logic                restore,
  input  logic                clear_start,
  input  logic [ADDR_W-1:0]   rd_addr0,
  output logic [WIDTH-1:0]    rd_data0,
  input  logic [ADDR_W-1:0]   rd_addr1,
  output logic [WIDTH-1:0]    rd_data1,
  output logic                busy,
  output logic [NUM_REGS-1:0] dirty,
  output logic                err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W:0]   REG_COUNT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

  logic [WIDTH-1:0]    regs     [NUM_REGS];
  logic [WIDTH-1:0]    regs_n   [NUM_REGS];
  logic [WIDTH-1:0]    shadow   [NUM_REGS];
  logic [WIDTH-1:0]    shadow_n [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_n;
  logic                err_n;
  logic [0:0]          state;
  logic [0:0]          state_n;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   cnt_n;

  logic [WIDTH-1:0]    val_a;
  logic [WIDTH-1:0]    val_b;
  logic                wr_ok;
  logic                swap_ok;
  logic                op_any;

  assign busy    = (state == CLEAR);
  assign wr_ok   = ({1'b0, wr_addr} < REG_COUNT);
  assign swap_ok = ({1'b0, swap_a} < REG_COUNT) && ({1'b0, swap_b} < REG_COUNT);
  assign op_any  = wr_en | swap_en | save | restore | clear_start;

  // Decoding by comparison against each index keeps out-of-range reads at zero.
  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    val_a    = '0;
    val_b    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr0 == ADDR_W'(i)) rd_data0 = regs[i];
      if (rd_addr1 == ADDR_W'(i)) rd_data1 = regs[i];
      if (swap_a == ADDR_W'(i))   val_a    = regs[i];
      if (swap_b == ADDR_W'(i))   val_b    = regs[i];
    end
  end

  always_comb begin
    regs_n   = regs;
    shadow_n = shadow;
    dirty_n  = dirty;
    err_n    = 1'b0;
    state_n  = state;
    cnt_n    = cnt;

    if (state == CLEAR) begin
      err_n = op_any;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cnt == ADDR_W'(i)) begin
          regs_n[i]  = '0;
          dirty_n[i] = 1'b1;
        end
      end
      if (cnt == LAST_REG) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else if (clear_start) begin
      state_n = CLEAR;
      cnt_n   = '0;
      err_n   = restore | save | swap_en | wr_en;
    end else if (restore) begin
      regs_n  = shadow;
      dirty_n = '0;
      err_n   = save | swap_en | wr_en;
    end else begin
      // Save clears dirty first so marks from this cycle's swap/write survive.
      if (save) begin
        shadow_n = regs;
        dirty_n  = '0;
      end
      if (swap_en) begin
        if (!swap_ok) begin
          err_n = 1'b1;
        end else if (swap_a != swap_b) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (swap_a == ADDR_W'(i)) begin
              regs_n[i]  = val_b;
              dirty_n[i] = 1'b1;
            end else if (swap_b == ADDR_W'(i)) begin
              regs_n[i]  = val_a;
              dirty_n[i] = 1'b1;
            end
          end
        end
      end
      if (wr_en) begin
        if (!wr_ok) begin
          err_n = 1'b1;
        end else begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
              regs_n[i]  = wr_data;
              dirty_n[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      dirty <= '0;
      err   <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      regs   <= regs_n;
      shadow <= shadow_n;
      dirty  <= dirty_n;
      err    <= err_n;
      state  <= state_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a 4-register and a 3-register instance share stimulus
// and are compared each cycle against a rule-level array model.
module tb_register_bank;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       swap_en;
  logic [1:0] swap_a;
  logic [1:0] swap_b;
  logic       save;
  logic       restore;
  logic       clear_start;
  logic [1:0] rd_addr0;
  logic [1:0] rd_addr1;

  logic [7:0] rd_data0_a, rd_data1_a;
  logic       busy_a, err_a;
  logic [3:0] dirty_a;
  logic [7:0] rd_data0_b, rd_data1_b;
  logic       busy_b, err_b;
  logic [2:0] dirty_b;

  int total;
  int bad;

  int m_reg    [2][4];
  int m_shadow [2][4];
  int m_dirty  [2][4];
  int m_err    [2];
  int m_clr    [2];

  register_bank #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_en(swap_en), .swap_a(swap_a), .swap_b(swap_b),
    .save(save), .restore(restore), .clear_start(clear_start),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0_a),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1_a),
    .busy(busy_a), .dirty(dirty_a), .err(err_a)
  );

  register_bank #(.WIDTH(8), .NUM_REGS(3), .ADDR_W(2)) dut3 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_en(swap_en), .swap_a(swap_a), .swap_b(swap_b),
    .save(save), .restore(restore), .clear_start(clear_start),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0_b),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1_b),
    .busy(busy_b), .dirty(dirty_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        m_reg[m][k]    = 0;
        m_shadow[m][k] = 0;
        m_dirty[m][k]  = 0;
      end
      m_err[m] = 0;
      m_clr[m] = -1;
    end
  endtask

  // Applies one rising edge worth of rules to both models, using pre-edge values.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int n;
      int old [4];
      int e;
      n = (m == 0) ? 4 : 3;
      e = 0;
      for (int k = 0; k < 4; k++) old[k] = m_reg[m][k];
      if (m_clr[m] >= 0) begin
        e = (wr_en || swap_en || save || restore || clear_start) ? 1 : 0;
        m_reg[m][m_clr[m]]   = 0;
        m_dirty[m][m_clr[m]] = 1;
        m_clr[m]++;
        if (m_clr[m] == n) m_clr[m] = -1;
      end else if (clear_start) begin
        m_clr[m] = 0;
        e = (restore || save || swap_en || wr_en) ? 1 : 0;
      end else if (restore) begin
        for (int k = 0; k < n; k++) begin
          m_reg[m][k]   = m_shadow[m][k];
          m_dirty[m][k] = 0;
        end
        e = (save || swap_en || wr_en) ? 1 : 0;
      end else begin
        if (save) begin
          for (int k = 0; k < n; k++) begin
            m_shadow[m][k] = old[k];
            m_dirty[m][k]  = 0;
          end
        end
        if (swap_en) begin
          if (int'(swap_a) >= n || int'(swap_b) >= n) e = 1;
          else if (swap_a != swap_b) begin
            m_reg[m][swap_a]   = old[swap_b];
            m_reg[m][swap_b]   = old[swap_a];
            m_dirty[m][swap_a] = 1;
            m_dirty[m][swap_b] = 1;
          end
        end
        if (wr_en) begin
          if (int'(wr_addr) >= n) e = 1;
          else begin
            m_reg[m][wr_addr]   = int'(wr_data);
            m_dirty[m][wr_addr] = 1;
          end
        end
      end
      m_err[m] = e;
    end
  endtask

  function automatic logic [31:0] exp_read(input int m, input logic [1:0] addr);
    int n;
    n = (m == 0) ? 4 : 3;
    return (int'(addr) < n) ? m_reg[m][addr] : 0;
  endfunction

  function automatic logic [31:0] exp_dirty(input int m);
    logic [31:0] v;
    int n;
    n = (m == 0) ? 4 : 3;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = (m_dirty[m][k] != 0);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input bit reads_only);
    checkValue({tag, "/a.rd0"}, 32'(rd_data0_a), exp_read(0, rd_addr0));
    checkValue({tag, "/a.rd1"}, 32'(rd_data1_a), exp_read(0, rd_addr1));
    checkValue({tag, "/b.rd0"}, 32'(rd_data0_b), exp_read(1, rd_addr0));
    checkValue({tag, "/b.rd1"}, 32'(rd_data1_b), exp_read(1, rd_addr1));
    if (!reads_only) begin
      checkValue({tag, "/a.busy"},  32'(busy_a),  32'(m_clr[0] >= 0));
      checkValue({tag, "/b.busy"},  32'(busy_b),  32'(m_clr[1] >= 0));
      checkValue({tag, "/a.dirty"}, 32'(dirty_a), exp_dirty(0));
      checkValue({tag, "/b.dirty"}, 32'(dirty_b), exp_dirty(1));
      checkValue({tag, "/a.err"},   32'(err_a),   32'(m_err[0]));
      checkValue({tag, "/b.err"},   32'(err_b),   32'(m_err[1]));
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks reads before the edge
  // (no bypass) and the full state just after it.
  task automatic applyStimulus(input string tag,
                               input bit we, input logic [1:0] wa, input logic [7:0] wd,
                               input bit se, input logic [1:0] sa, input logic [1:0] sb,
                               input bit sv, input bit rs, input bit cs,
                               input logic [1:0] ra0, input logic [1:0] ra1);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    swap_en = se; swap_a = sa; swap_b = sb;
    save = sv; restore = rs; clear_start = cs;
    rd_addr0 = ra0; rd_addr1 = ra1;
    #1;
    checkOutput({tag, ".pre"}, 1'b1);
    @(posedge clk);
    model_step();
    #1;
    checkOutput(tag, 1'b0);
  endtask

  task automatic idle(input string tag, input logic [1:0] ra0, input logic [1:0] ra1);
    applyStimulus(tag, 0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 0, 0, 0, ra0, ra1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    swap_en = 0; swap_a = 0; swap_b = 0;
    save = 0; restore = 0; clear_start = 0;
    rd_addr0 = 0; rd_addr1 = 1;
    model_reset();
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkOutput("reset", 1'b0);
    @(negedge clk) reset = 1'b1;

    applyStimulus("wr_r0", 1, 2'd0, 8'h11, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 2'd1);
    applyStimulus("wr_r1", 1, 2'd1, 8'h22, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 2'd1);
    checkValue("plan_wr.rd0", 32'(rd_data0_a), 32'h11);
    checkValue("plan_wr.rd1", 32'(rd_data1_a), 32'h22);
    checkValue("plan_wr.dirty", 32'(dirty_a), 32'h3);

    applyStimulus("swap_wr", 1, 2'd1, 8'h55, 1, 2'd0, 2'd1, 0, 0, 0, 2'd0, 2'd1);
    checkValue("plan_swap.rd0", 32'(rd_data0_a), 32'h22);
    checkValue("plan_swap.rd1", 32'(rd_data1_a), 32'h55);
    checkValue("plan_swap.err", 32'(err_a), 32'h0);
    applyStimulus("swap_same", 0, 2'd0, 8'h00, 1, 2'd2, 2'd2, 0, 0, 0, 2'd2, 2'd3);

    for (int i = 0; i < 4; i++)
      applyStimulus("fill", 1, 2'(i), 8'(i + 1), 0, 2'd0, 2'd0, 0, 0, 0, 2'(i), 2'd3);
    applyStimulus("save", 0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 1, 0, 0, 2'd2, 2'd3);
    checkValue("plan_save.dirty", 32'(dirty_a), 32'h0);
    applyStimulus("wr_r2", 1, 2'd2, 8'hAA, 0, 2'd0, 2'd0, 0, 0, 0, 2'd2, 2'd3);
    checkValue("plan_dirty_r2", 32'(dirty_a), 32'h4);
    applyStimulus("restore", 0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 0, 1, 0, 2'd2, 2'd3);
    checkValue("plan_restore.rd0", 32'(rd_data0_a), 32'h3);
    checkValue("plan_restore.dirty", 32'(dirty_a), 32'h0);

    applyStimulus("clr_conflict", 0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 0, 1, 1, 2'd0, 2'd3);
    checkValue("plan_clr.err", 32'(err_a), 32'h1);
    checkValue("plan_clr.busy", 32'(busy_a), 32'h1);
    idle("clr1", 2'd0, 2'd1);
    applyStimulus("clr_wr", 1, 2'd3, 8'h77, 0, 2'd0, 2'd0, 0, 0, 0, 2'd2, 2'd3);
    checkValue("plan_busy_wr.err", 32'(err_a), 32'h1);
    idle("clr3", 2'd2, 2'd3);
    idle("clr4", 2'd2, 2'd3);
    checkValue("plan_clr_done.busy", 32'(busy_a), 32'h0);
    checkValue("plan_clr_done.dirty", 32'(dirty_a), 32'hF);
    checkValue("plan_clr_done.r3", 32'(rd_data1_a), 32'h0);

    for (int i = 0; i < 4; i++)
      applyStimulus("refill", 1, 2'(i), 8'(8'hC0 + i), 0, 2'd0, 2'd0, i == 3, 0, 0, 2'd0, 2'd3);
    applyStimulus("clr_start", 0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 0, 0, 1, 2'd0, 2'd3);
    idle("clr_mid1", 2'd0, 2'd3);
    idle("clr_mid2", 2'd0, 2'd3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset", 1'b0);
    @(posedge clk);
    #1 checkOutput("reset_hold", 1'b0);
    @(negedge clk) reset = 1'b1;
    applyStimulus("post_reset_wr", 1, 2'd3, 8'h3C, 0, 2'd0, 2'd0, 0, 0, 0, 2'd3, 2'd0);
    checkValue("plan_reset.r3", 32'(rd_data0_a), 32'h3C);
    applyStimulus("restore_zero", 0, 2'd0, 8'h00, 0, 2'd0, 2'd0, 0, 1, 0, 2'd3, 2'd0);
    checkValue("plan_shadow_zero", 32'(rd_data0_a), 32'h0);

    applyStimulus("illegal_wr", 1, 2'd3, 8'h99, 0, 2'd0, 2'd0, 0, 0, 0, 2'd3, 2'd0);
    checkValue("plan_illegal.err", 32'(err_b), 32'h1);
    checkValue("plan_illegal.rd", 32'(rd_data0_b), 32'h0);
    applyStimulus("illegal_swap", 1, 2'd0, 8'h5A, 1, 2'd3, 2'd1, 0, 0, 0, 2'd0, 2'd1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    $urandom_range(0, 1) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
                    $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 19) == 0,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
Parametrised successor to the two-register A/B operand store in front of the ALU. It holds NUM_REGS registers of WIDTH bits and provides:
- two combinational read ports and one write port
- swap of any two registers
- a one-cycle shadow save/restore
- a multi-cycle sequential clear driven by a small FSM

Per-register dirty flags track changes since the last save. Operand selection for the ALU reads rd_data0 and rd_data1.

Parameters:
WIDTH, 8, data width of each register.
NUM_REGS, 4, number of architectural registers (>=2, need not be a power of two).
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
wr_en  in  1  write request.
wr_addr  in  ADDR_W  write target.
wr_data  in  WIDTH  write data.
swap_en  in  1  swap request.
swap_a  in  ADDR_W  first swap operand.
swap_b  in  ADDR_W  second swap operand.
save  in  1  copy all registers to the shadow bank.
restore  in  1  copy the shadow bank to all registers.
clear_start  in  1  start the sequential clear.
rd_addr0  in  ADDR_W  read port 0 address.
rd_data0  out  WIDTH  combinational read of reg[rd_addr0].
rd_addr1  in  ADDR_W  read port 1 address.
rd_data1  out  WIDTH  combinational read of reg[rd_addr1].
busy  out  1  high while the clear is in progress.
dirty  out  NUM_REGS  bit i set when reg i has changed since the last save or restore.
err  out  1  one-cycle pulse on a dropped or illegal operation.

Behaviour:
- Reset (reset=0, async):
  - all regs, shadow bank, dirty and err cleared to 0; busy=0.
  - FSM goes to IDLE and the clear counter to 0.
  - Aborts any clear in progress.
- Reads:
  - combinational; no write bypass, so a read in the same cycle as a write returns the old value.
  - address >= NUM_REGS returns 0.
- Op classes (IDLE only):
  - Exclusive ops: clear_start, restore. Combinable ops: save, swap_en, wr_en.
  - Exclusive op alone: it executes.
  - Exclusive op with any other op: clear_start wins over restore; every other op is dropped; err=1 next cycle.
- Combinable ops, same edge, all sampled from pre-edge state:
  - save: shadow <= pre-edge regs; all dirty bits cleared.
  - swap with swap_a != swap_b: reg[a] <= old reg[b] and reg[b] <= old reg[a]; dirty[a] and dirty[b] set.
  - swap with swap_a == swap_b: no-op; no dirty change; no err.
  - write: reg[wr_addr] <= wr_data and dirty[wr_addr] set. Applied after the swap, so write wins on an address conflict.
  - Dirty set by a write or swap in the same cycle as save stays set.
- Restore: all regs <= shadow; all dirty bits cleared.
- Out-of-range address on any op: that op is ignored; err=1. Other valid ops in the cycle still execute.
- Clear FSM:
  - IDLE -> CLEAR on clear_start. busy=1 from the next edge.
  - In CLEAR, counter k = 0..NUM_REGS-1: reg[k] <= 0 and dirty[k] set, one register per cycle.
  - After clearing reg[NUM_REGS-1], returns to IDLE with busy=0.
  - busy is high for exactly NUM_REGS cycles.
  - Shadow bank is untouched.
  - Reads during CLEAR return current, partially cleared contents.
- During busy: all op inputs are ignored; err=1 for each cycle in which any op is asserted.
- err is a registered pulse that lasts one cycle per offending cycle; otherwise 0.

Test Plan:
- Write and read (WIDTH=8, NUM_REGS=4): write 0x11 to r0, 0x22 to r1; read addresses 0,1 -> rd_data0=0x11, rd_data1=0x22; dirty=4'b0011.
- Swap with write: r0=0x11, r1=0x22; swap_en(a=0,b=1) and wr_en(addr=1,data=0x55) on one edge -> r0=0x22, r1=0x55; err=0.
- Save/restore: save with r0..r3 = 1,2,3,4 -> dirty=0. Write r2=0xAA -> dirty=4'b0100. Restore -> r2=3, dirty=0.
- Clear with conflict:
  - clear_start together with restore -> clear executes, err pulses once.
  - busy then high for 4 cycles; regs zeroed r0..r3 in order; dirty=4'b1111.
  - wr_en asserted during busy -> err=1 that cycle, register unchanged.
- Reset mid-clear: assert reset=0 two cycles into the clear -> all regs and shadow 0, busy=0, dirty=0 immediately. After release, a write to r3 succeeds.
- Illegal address (NUM_REGS=3, ADDR_W=2): write to addr 3 -> ignored, err=1. Read of addr 3 -> 0.
